// File: rtl/reduce_pkg.sv
//==============================================================================
// reduce_pkg : op encodings, FSM states and op decoding for reduce_gate_seq
// Revision   : 1.0
//==============================================================================
`default_nettype none

package reduce_pkg;

  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_OR     = 3'd1;
  localparam logic [2:0] OP_XOR    = 3'd2;
  localparam logic [2:0] OP_NAND   = 3'd3;
  localparam logic [2:0] OP_NOR    = 3'd4;
  localparam logic [2:0] OP_XNOR   = 3'd5;
  localparam logic [2:0] OP_RSV_LO = 3'd6;
  localparam logic [2:0] OP_RSV_HI = 3'd7;

  typedef enum logic [1:0] {
    BASE_AND = 2'd0,
    BASE_OR  = 2'd1,
    BASE_XOR = 2'd2
  } base_e;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  typedef struct packed {
    base_e base;
    logic  inv;
    logic  rsv;
  } op_info_t;

  // Inverting ops share the base function of their non-inverting partner.
  function automatic op_info_t decode_op(input logic [2:0] op);
    op_info_t info;
    info.rsv = op inside {[OP_RSV_LO:OP_RSV_HI]};
    info.inv = op inside {OP_NAND, OP_NOR, OP_XNOR};
    case (op)
      OP_AND, OP_NAND: info.base = BASE_AND;
      OP_OR,  OP_NOR:  info.base = BASE_OR;
      OP_XOR, OP_XNOR: info.base = BASE_XOR;
      default:         info.base = BASE_AND;
    endcase
    return info;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reduce_word.sv
//==============================================================================
// reduce_word : combinational reduction of one word to a single bit
// Revision    : 1.0
//==============================================================================
`default_nettype none

module reduce_word
  import reduce_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  base_e            base,
  output logic             r
);

  always_comb begin
    r = 1'b0;
    case (base)
      BASE_AND: r = &data;
      BASE_OR:  r = |data;
      BASE_XOR: r = ^data;
      default:  r = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/reduce_gate_seq.sv
//==============================================================================
// reduce_gate_seq : folds per-word reductions across a framed valid/ready stream
// Revision        : 1.0
//==============================================================================
`default_nettype none

module reduce_gate_seq
  import reduce_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_result,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state, state_nxt;
  logic [2:0]       op_q;
  logic             acc;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             first;
  logic             done;
  logic [2:0]       op_eff;
  op_info_t         info;
  logic             r;
  logic             acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign done     = accept && in_last;
  assign first    = (state == IDLE);
  // The op is taken live on the first beat and from the latch afterwards.
  assign op_eff   = first ? op : op_q;
  assign info     = decode_op(op_eff);

  reduce_word #(
    .WIDTH (WIDTH)
  ) u_word (
    .data (in_data),
    .base (info.base),
    .r    (r)
  );

  always_comb begin
    acc_nxt = r;
    if (!first) begin
      case (info.base)
        BASE_AND: acc_nxt = acc & r;
        BASE_OR:  acc_nxt = acc | r;
        BASE_XOR: acc_nxt = acc ^ r;
        default:  acc_nxt = r;
      endcase
    end
  end

  always_comb begin
    cnt_nxt = CNT_W'(1);
    if (!first) begin
      cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = in_last ? IDLE : ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= 1'b0;
      op_q <= 3'd0;
      cnt  <= '0;
    end else if (accept) begin
      acc  <= acc_nxt;
      op_q <= op_eff;
      cnt  <= cnt_nxt;
    end
  end

  // Inversion is applied once at completion, never per beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= 1'b0;
      out_count  <= '0;
      out_err    <= 1'b0;
    end else if (done) begin
      out_valid  <= 1'b1;
      out_result <= info.rsv ? 1'b0 : (acc_nxt ^ info.inv);
      out_count  <= cnt_nxt;
      out_err    <= info.rsv;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reduce_gate_seq.sv
//==============================================================================
// tb_reduce_gate_seq : vector table, sweep, corner sequences and random frames
// Revision           : 1.0
//==============================================================================
`default_nettype none

module tb_reduce_gate_seq;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic             out_result;
  logic [CNT_W-1:0] out_count;
  logic             out_err;

  reduce_gate_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .op         (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_count  (out_count),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0][7:0] d;
    logic [2:0]      o0;
    logic [2:0]      o1;
    logic [2:0]      n;
    logic            res;
    logic            err;
  } vec_t;

  typedef struct {
    logic res;
    int   cnt;
    logic err;
  } exp_t;

  exp_t sb[$];
  bit   mon_en  = 1'b0;
  bit   rnd_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the frame result depends only on how many of its bits are ones.
  function automatic logic ref_frame(input int ones, input int bits, input logic [2:0] o);
    logic res;
    if (o >= 3'd6) return 1'b0;
    case (int'(o) % 3)
      0:       res = (ones == bits);
      1:       res = (ones > 0);
      default: res = (ones % 2) == 1;
    endcase
    return (o >= 3'd3) ? !res : res;
  endfunction

  function automatic vec_t mk(input int n, input logic [7:0] d0, d1, d2, d3,
                              input logic [2:0] o0, o1, input logic res, err);
    vec_t v;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.o0 = o0; v.o1 = o1; v.n = 3'(n); v.res = res; v.err = err;
    return v;
  endfunction

  // Holds a beat until accepted; returns at 1 time unit past the accepting edge.
  task automatic beat(input logic [7:0] d, input logic l, input logic [2:0] o);
    bit ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l; op = o;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      @(posedge clk); #1;
    end else begin
      tests++; fails++;
      $display("FAIL beat_timeout: got in_ready 0 expected 1 within 100 cycles");
    end
    in_valid = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL rnd_spurious: got unexpected result expected none");
        end else begin
          e = sb.pop_front();
          check("rnd_res", 64'(out_result), 64'(e.res));
          check("rnd_cnt", 64'(out_count), 64'(e.cnt));
          check("rnd_err", 64'(out_err), 64'(e.err));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    vec_t vt[10];
    vt[0] = mk(1, 8'h00, 8'h00, 8'h00, 8'h00, 3'd1, 3'd1, 1'b0, 1'b0);
    vt[1] = mk(1, 8'h10, 8'h00, 8'h00, 8'h00, 3'd1, 3'd1, 1'b1, 1'b0);
    vt[2] = mk(3, 8'hFF, 8'hFF, 8'hFE, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
    vt[3] = mk(3, 8'hFF, 8'hFF, 8'hFE, 8'h00, 3'd3, 3'd3, 1'b1, 1'b0);
    vt[4] = mk(2, 8'h01, 8'h03, 8'h00, 8'h00, 3'd2, 3'd0, 1'b1, 1'b0);
    vt[5] = mk(1, 8'hFF, 8'h00, 8'h00, 8'h00, 3'd6, 3'd6, 1'b0, 1'b1);
    vt[6] = mk(2, 8'h00, 8'h00, 8'h00, 8'h00, 3'd4, 3'd4, 1'b1, 1'b0);
    vt[7] = mk(2, 8'h03, 8'h01, 8'h00, 8'h00, 3'd5, 3'd5, 1'b0, 1'b0);
    vt[8] = mk(2, 8'hFF, 8'hFF, 8'h00, 8'h00, 3'd7, 3'd1, 1'b0, 1'b1);
    vt[9] = mk(4, 8'h80, 8'h00, 8'h00, 8'h00, 3'd1, 3'd5, 1'b1, 1'b0);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; op = 3'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(out_result), 64'd0);
    check("rst_count", 64'(out_count), 64'd0);
    check("rst_err", 64'(out_err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 10; i++) begin
      for (int b = 0; b < int'(vt[i].n); b++)
        beat(vt[i].d[b], b == int'(vt[i].n) - 1, (b == 0) ? vt[i].o0 : vt[i].o1);
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_res", i), 64'(out_result), 64'(vt[i].res));
      check($sformatf("vec%0d_cnt", i), 64'(out_count), 64'(vt[i].n));
      check($sformatf("vec%0d_err", i), 64'(out_err), 64'(vt[i].err));
    end

    for (int o = 0; o < 6; o++) begin
      for (int d = 0; d < 256; d++) begin
        beat(8'(d), 1'b1, 3'(o));
        check($sformatf("sweep_op%0d_d%0h_res", o, d), 64'(out_result),
              64'(ref_frame($countones(8'(d)), 8, 3'(o))));
        check($sformatf("sweep_op%0d_d%0h_err", o, d), 64'(out_err), 64'd0);
      end
    end

    // Backpressure: stall the stream, then drain and reload on one edge.
    beat(8'h10, 1'b1, 3'd1);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hFE; in_last = 1'b1; op = 3'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_res", 64'(out_result), 64'd1);
      check("bp_hold_cnt", 64'(out_count), 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_reload_valid", 64'(out_valid), 64'd1);
    check("bp_reload_res", 64'(out_result), 64'd0);
    check("bp_reload_cnt", 64'(out_count), 64'd1);
    @(posedge clk); #1;
    check("bp_drain_valid", 64'(out_valid), 64'd0);
    check("bp_drain_res_kept", 64'(out_result), 64'd0);
    check("bp_drain_cnt_kept", 64'(out_count), 64'd1);

    // Reset mid-frame: the partial AND frame must leave no trace.
    beat(8'hFF, 1'b0, 3'd0);
    beat(8'hFF, 1'b0, 3'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    beat(8'h80, 1'b1, 3'd1);
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_res", 64'(out_result), 64'd1);
    check("post_rst_cnt", 64'(out_count), 64'd1);
    check("post_rst_err", 64'(out_err), 64'd0);
    @(posedge clk); #1;

    // Random frames with random backpressure against the bit-count model.
    mon_en = 1'b1;
    rnd_rdy = 1'b1;
    for (int f = 0; f < 300; f++) begin
      logic [2:0] op0;
      int n, ones;
      exp_t e;
      op0 = 3'($urandom_range(0, 7));
      n = $urandom_range(1, 5);
      ones = 0;
      for (int b = 0; b < n; b++) begin
        logic [7:0] d;
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
        d = 8'($urandom);
        ones += $countones(d);
        beat(d, b == n - 1, (b == 0) ? op0 : 3'($urandom_range(0, 7)));
      end
      e.res = ref_frame(ones, 8 * n, op0);
      e.cnt = n;
      e.err = (op0 >= 3'd6);
      sb.push_back(e);
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rnd_all_drained", 64'(sb.size()), 64'd0);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
